// File: rtl/fog_demod_pkg.sv
// rtl/fog_demod_pkg.sv - shared types and limits for the FOG square-wave demodulator
package fog_demod_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_POS  = 2'd1,
    DM_NEG  = 2'd2
  } demod_state_t;

  localparam int unsigned MIN_HALF_PERIOD = 2;

  // Working width for the saturating subtract; must exceed ADC_W+CNT_W+2 and ERR_W.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_max(input int w);
    logic signed [SAT_W-1:0] one;
    one = 1;
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_min(input int w);
    logic signed [SAT_W-1:0] one;
    one = 1;
    return -(one <<< (w - 1));
  endfunction

endpackage

// File: rtl/sync_pulse_delay.sv
// rtl/sync_pulse_delay.sv - shift-register delay of a single-clock pulse
module sync_pulse_delay #(
  parameter int DLY = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pulse,
  output logic o_pulse
);

  logic [DLY-1:0] sr_q;
  logic [DLY-1:0] sr_d;

  always_comb begin
    sr_d = (sr_q << 1) | DLY'(i_pulse);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign o_pulse = sr_q[DLY-1];

endmodule

// File: rtl/err_demod_sync_gen.sv
// rtl/err_demod_sync_gen.sv - square-wave modulation, half-period integration and error/strobe generation
module err_demod_sync_gen
  import fog_demod_pkg::*;
#(
  parameter int ADC_W    = 14,
  parameter int CNT_W    = 16,
  parameter int ERR_W    = 32,
  parameter int SYNC_DLY = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic signed [ADC_W-1:0] i_adc,
  input  logic [CNT_W-1:0]        i_half_period,
  input  logic [CNT_W-1:0]        i_wait_cnt,
  input  logic                    i_polarity,
  output logic                    o_mod_sq,
  output logic [ERR_W-1:0]        o_err,
  output logic                    o_step_sync,
  output logic                    o_step_sync_dly
);

  localparam int ACC_W = ADC_W + CNT_W;
  localparam logic signed [SAT_W-1:0] ERR_MAX = sat_max(ERR_W);
  localparam logic signed [SAT_W-1:0] ERR_MIN = sat_min(ERR_W);

  demod_state_t             state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         hp_q, hp_d;
  logic [CNT_W-1:0]         wt_q, wt_d;
  logic signed [ACC_W-1:0]  acc_p_q, acc_p_d;
  logic signed [ACC_W-1:0]  acc_n_q, acc_n_d;
  logic                     wrap_q, wrap_d;
  logic                     upd_q, upd_d;
  logic                     sync_q, sync_d;
  logic                     mod_sq_q, mod_sq_d;
  logic [ERR_W-1:0]         err_q, err_d;

  logic                     last_smp;
  logic                     take_smp;
  logic [CNT_W-1:0]         hp_in;
  logic signed [ACC_W-1:0]  adc_ext;
  logic signed [ACC_W-1:0]  acc_p_base;
  logic signed [SAT_W-1:0]  diff;
  logic [ERR_W-1:0]         err_sat;

  always_comb begin
    diff = {{(SAT_W-ACC_W){acc_p_q[ACC_W-1]}}, acc_p_q}
         - {{(SAT_W-ACC_W){acc_n_q[ACC_W-1]}}, acc_n_q};
    if (i_polarity) begin
      diff = -diff;
    end
    if (diff > ERR_MAX) begin
      err_sat = ERR_MAX[ERR_W-1:0];
    end else if (diff < ERR_MIN) begin
      err_sat = ERR_MIN[ERR_W-1:0];
    end else begin
      err_sat = diff[ERR_W-1:0];
    end
  end

  always_comb begin
    last_smp   = (cnt_q == hp_q - CNT_W'(1));
    take_smp   = (cnt_q >= wt_q);
    hp_in      = (i_half_period < CNT_W'(MIN_HALF_PERIOD)) ? CNT_W'(MIN_HALF_PERIOD) : i_half_period;
    adc_ext    = {{CNT_W{i_adc[ADC_W-1]}}, i_adc};
    // First POS clock after a wrap is cycle E: the finished period is folded into o_err here.
    acc_p_base = wrap_q ? '0 : acc_p_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    wt_d    = wt_q;
    acc_p_d = acc_p_q;
    acc_n_d = acc_n_q;
    err_d   = err_q;
    wrap_d  = 1'b0;
    upd_d   = 1'b0;
    sync_d  = upd_q;

    if (!i_en) begin
      state_d = DM_IDLE;
      cnt_d   = '0;
      acc_p_d = '0;
      acc_n_d = '0;
    end else begin
      case (state_q)
        DM_IDLE: begin
          state_d = DM_POS;
          cnt_d   = '0;
          hp_d    = hp_in;
          wt_d    = i_wait_cnt;
        end
        DM_POS: begin
          acc_p_d = take_smp ? acc_p_base + adc_ext : acc_p_base;
          if (wrap_q) begin
            acc_n_d = '0;
            err_d   = err_sat;
            upd_d   = 1'b1;
          end
          if (last_smp) begin
            state_d = DM_NEG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DM_NEG: begin
          if (take_smp) begin
            acc_n_d = acc_n_q + adc_ext;
          end
          if (last_smp) begin
            state_d = DM_POS;
            cnt_d   = '0;
            hp_d    = hp_in;
            wt_d    = i_wait_cnt;
            wrap_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = DM_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    mod_sq_d = (state_d == DM_POS);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= DM_IDLE;
      cnt_q    <= '0;
      hp_q     <= '0;
      wt_q     <= '0;
      acc_p_q  <= '0;
      acc_n_q  <= '0;
      wrap_q   <= 1'b0;
      upd_q    <= 1'b0;
      sync_q   <= 1'b0;
      mod_sq_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hp_q     <= hp_d;
      wt_q     <= wt_d;
      acc_p_q  <= acc_p_d;
      acc_n_q  <= acc_n_d;
      wrap_q   <= wrap_d;
      upd_q    <= upd_d;
      sync_q   <= sync_d;
      mod_sq_q <= mod_sq_d;
      err_q    <= err_d;
    end
  end

  sync_pulse_delay #(
    .DLY (SYNC_DLY)
  ) u_sync_dly (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_pulse (sync_q),
    .o_pulse (o_step_sync_dly)
  );

  assign o_mod_sq    = mod_sq_q;
  assign o_err       = err_q;
  assign o_step_sync = sync_q;

endmodule
